uart_tx: RTL

//  Serialises one byte per request onto an 8-N-1 (configurable) UART line.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per accepted request, LSB first,
// with optional parity and 1 or 2 stop bits.
//
// Parameters:
//   CLKS_PER_BIT  clocks per bit period (>= 2)
//   PARITY        0 none, 1 odd, 2 even
//   STOP_BITS     1 or 2
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_tx_dv      send request, honoured only while o_tx_ready=1
//   i_tx_byte    byte to send, captured on accept
//   o_tx_ready   idle and able to accept this cycle
//   o_tx_active  high from first start-bit cycle to last stop-bit cycle
//   o_tx_serial  UART line, idle high
//   o_tx_done    one-cycle pulse after the final stop bit
module uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_active,
  output logic       o_tx_serial,
  output logic       o_tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(CLKS_PER_BIT - 1);
  // Index of the last stop bit (0 for one, 1 for two).
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic HAS_PAR   = (PARITY != 0);
  localparam logic ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            serial_q, serial_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + CW'(1);
    bit_d    = bit_q;
    stop_d   = stop_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        active_d = 1'b0;
        if (i_tx_dv) begin
          state_d  = START;
          shreg_d  = i_tx_byte;
          par_d    = ODD_PAR ? ~^i_tx_byte
                             : ^i_tx_byte;
          bit_d    = '0;
          stop_d   = 1'b0;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          serial_d = shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bit_d    = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d  = HAS_PAR ? PAR : STOP;
            serial_d = HAS_PAR ? par_q : 1'b1;
            stop_d   = 1'b0;
          end else begin
            serial_d = shreg_q[0];
            shreg_d  = shreg_q >> 1;
            bit_d    = bit_q + 3'd1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
          stop_d   = 1'b0;
        end
      end
      STOP: begin
        serial_d = 1'b1;
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d  = IDLE;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  // Ready is state-derived so it drops while reset is held.
  assign o_tx_ready  = (state_q == IDLE) && !i_reset;
  assign o_tx_active = active_q;
  assign o_tx_serial = serial_q;
  assign o_tx_done   = done_q;

endmodule
